// File: rtl/udp_tx_buffer_pkg.sv
// Shared definitions for the UDP transmit payload buffer: FSM encoding,
// transmitter idle code and payload byte-count arithmetic.
package udp_tx_buffer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FILL  = 2'd0;
    localparam state_t ARM   = 2'd1;
    localparam state_t SEND  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    localparam logic [3:0] TX_IDLE = 4'd0;

    // Bytes in a packet given the words before the last one and the last word's byte count.
    function automatic logic [13:0] byte_count(input logic [13:0] prior_words,
                                               input logic [1:0]  nbytes);
        logic [13:0] tail;
        tail = (nbytes == 2'd0) ? 14'd4 : {12'd0, nbytes};
        return (prior_words << 2) + tail;
    endfunction

endpackage

// File: rtl/udp_tx_buffer_if.sv
// Payload word stream into the UDP transmit buffer (valid/ready handshake).
interface udp_tx_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_nbytes;

    modport master (output in_valid, in_data, in_last, in_nbytes, input in_ready);
    modport slave  (input in_valid, in_data, in_last, in_nbytes, output in_ready);
endinterface

// File: rtl/udp_tx_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
// Reads beyond the populated depth return zero.
module udp_tx_ram #(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 13,
    parameter int IDX_W       = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);
    logic [31:0] mem [DEPTH_WORDS];
    logic        in_range;

    assign in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (in_range) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/udp_tx_buffer.sv
// Collects one payload packet into RAM, pads it to the minimum length,
// hands it to ipsend and waits for the transmitter to go idle again.
module udp_tx_buffer #(
    parameter int         DEPTH_WORDS = 512,
    parameter int         ADDR_W      = 13,
    parameter int         MIN_BYTES   = 18,
    parameter logic [3:0] TX_IDLE     = udp_tx_buffer_pkg::TX_IDLE
) (
    input  logic              e_rxc,
    input  logic              reset_n,
    udp_tx_buffer_if.slave    pay,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    output logic [31:0]       ram_rd_data,
    input  logic [3:0]        tx_state,
    output logic [13:0]       Data_Length,
    output logic              ipsend_en,
    output logic              busy,
    output logic              overflow
);
    import udp_tx_buffer_pkg::*;

    localparam int PTR_W   = ADDR_W + 1;
    localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PAD_RAW = (MIN_BYTES + 3) / 4;
    localparam int PAD_LIM = (PAD_RAW < DEPTH_WORDS) ? PAD_RAW : DEPTH_WORDS;

    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH_WORDS);
    localparam logic [PTR_W-1:0] PAD_PTR   = PTR_W'(PAD_LIM);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [13:0]      MIN_LEN   = 14'(MIN_BYTES);
    localparam logic [13:0]      MAX_LEN   = 14'(4 * DEPTH_WORDS);

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [13:0]       len_reg, len_next;
    logic              ipsend_en_reg, ipsend_en_next;
    logic              overflow_reg, overflow_next;

    logic              accept;
    logic              full;
    logic              pad_pending;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [13:0]       count_bytes;
    logic [13:0]       last_len;

    assign accept      = pay.in_valid && (state_reg == FILL);
    assign full        = (wr_ptr_reg == DEPTH_PTR);
    assign pad_pending = (wr_ptr_reg < PAD_PTR);
    assign wr_en       = (accept && !full) || ((state_reg == ARM) && pad_pending);
    assign wr_data     = (state_reg == FILL) ? pay.in_data : 32'd0;

    // Once the RAM is full every further word is dropped, so the length pins at capacity.
    assign count_bytes = full ? MAX_LEN : byte_count(14'(wr_ptr_reg), pay.in_nbytes);
    assign last_len    = (count_bytes < MIN_LEN) ? MIN_LEN : count_bytes;

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        len_next       = len_reg;
        ipsend_en_next = ipsend_en_reg;
        overflow_next  = overflow_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (full) begin
                        overflow_next = 1'b1;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    end
                    if (pay.in_last) begin
                        len_next   = last_len;
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (pad_pending) begin
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                end else begin
                    wr_ptr_next    = '0;
                    ipsend_en_next = 1'b1;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (tx_state != TX_IDLE) begin
                    ipsend_en_next = 1'b0;
                    state_next     = DRAIN;
                end
            end
            default: begin
                if (tx_state == TX_IDLE) begin
                    state_next = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge e_rxc) begin
        if (!reset_n) begin
            state_reg     <= FILL;
            wr_ptr_reg    <= '0;
            len_reg       <= '0;
            ipsend_en_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            len_reg       <= len_next;
            ipsend_en_reg <= ipsend_en_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign pay.in_ready = (state_reg == FILL);
    assign busy         = (state_reg != FILL);
    assign Data_Length  = len_reg;
    assign ipsend_en    = ipsend_en_reg;
    assign overflow     = overflow_reg;

    udp_tx_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (e_rxc),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[IDX_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_udp_tx_buffer.sv
// Scoreboard bench: two buffers (deep and 8-word) see identical stimulus and
// are compared against a packet-level reference model.
module tb_udp_tx_buffer;

    localparam int DEP_A     = 512;
    localparam int DEP_B     = 8;
    localparam int REF_N     = 16;
    localparam int MIN_B     = 18;
    localparam int PAD_WORDS = (MIN_B + 3) / 4;

    typedef struct {
        logic [13:0] len;
        logic        ovf;
    } pkt_t;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        int          addr;
    } rd_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [12:0] ram_rd_addr;
    logic [3:0]  tx_state;
    logic [31:0] rd_data_a, rd_data_b;
    logic [13:0] len_a, len_b;
    logic        en_a, en_b, busy_a, busy_b, ovf_a, ovf_b;

    udp_tx_buffer_if pay_a();
    udp_tx_buffer_if pay_b();

    udp_tx_buffer #(.DEPTH_WORDS(DEP_A)) dut_a (
        .e_rxc(clk), .reset_n(reset_n), .pay(pay_a),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd_data_a), .tx_state(tx_state),
        .Data_Length(len_a), .ipsend_en(en_a), .busy(busy_a), .overflow(ovf_a)
    );

    udp_tx_buffer #(.DEPTH_WORDS(DEP_B)) dut_b (
        .e_rxc(clk), .reset_n(reset_n), .pay(pay_b),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd_data_b), .tx_state(tx_state),
        .Data_Length(len_b), .ipsend_en(en_b), .busy(busy_b), .overflow(ovf_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [2][REF_N];
    logic        ref_ok  [2][REF_N];
    logic        ref_ovf [2];
    int          depth_of [2] = '{DEP_A, DEP_B};
    logic [31:0] pkt_words [REF_N];

    pkt_t pkt_q_a[$], pkt_q_b[$];
    rd_t  rd_q_a[$],  rd_q_b[$];
    pkt_t pa, pb;
    rd_t  ra, rb;

    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;
    logic prev_en_a = 1'b0;
    logic prev_en_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic [1:0] nb);
        pay_a.in_valid = v; pay_a.in_data = d; pay_a.in_last = l; pay_a.in_nbytes = nb;
        pay_b.in_valid = v; pay_b.in_data = d; pay_b.in_last = l; pay_b.in_nbytes = nb;
    endtask

    // Reference: a packet's length and RAM image follow directly from its word count.
    task automatic model_pkt(input int n, input logic [1:0] nb);
        for (int k = 0; k < 2; k++) begin
            int   dep, total, len;
            pkt_t p;
            dep   = depth_of[k];
            total = 4 * (n - 1) + ((nb == 2'd0) ? 4 : int'(nb));
            len   = (total > 4 * dep) ? 4 * dep : total;
            if (len < MIN_B) len = MIN_B;
            if (n > dep) ref_ovf[k] = 1'b1;
            for (int i = 0; i < REF_N && i < dep; i++) begin
                if (i < n) begin
                    ref_mem[k][i] = pkt_words[i];
                    ref_ok[k][i]  = 1'b1;
                end else if (i < PAD_WORDS) begin
                    ref_mem[k][i] = 32'd0;
                    ref_ok[k][i]  = 1'b1;
                end
            end
            p.len = 14'(len);
            p.ovf = ref_ovf[k];
            if (k == 0) pkt_q_a.push_back(p);
            else        pkt_q_b.push_back(p);
        end
    endtask

    function automatic rd_t exp_rd(input int k, input int a);
        rd_t r;
        r.addr = a;
        r.chk  = 1'b0;
        r.exp  = 32'd0;
        if (a >= depth_of[k]) begin
            r.chk = 1'b1;
        end else if (a < REF_N && ref_ok[k][a]) begin
            r.chk = 1'b1;
            r.exp = ref_mem[k][a];
        end
        return r;
    endfunction

    task automatic issue_read(input int a);
        ram_rd_addr = 13'(a);
        rd_req      = 1'b1;
        rd_q_a.push_back(exp_rd(0, a));
        rd_q_b.push_back(exp_rd(1, a));
        @(negedge clk);
    endtask

    task automatic send_pkt(input int n, input logic [1:0] nb, input int gap_max,
                            input int hold_idle, input bit offer, input bit rst_in_send);
        int t, k, stored, pad, nread;
        for (int i = 0; i < n; i++) pkt_words[i] = $urandom;
        model_pkt(n, nb);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            drive(1'b0, 32'd0, 1'b0, 2'd0);
            repeat (gaps) @(negedge clk);
            drive(1'b1, pkt_words[i], (i == n - 1), (i == n - 1) ? nb : 2'($urandom));
            t = 0;
            while (!pay_a.in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check("handshake_timeout", 32'(t), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b0, 32'd0, 1'b0, 2'd0);
        check("ready_after_last_a", 32'(pay_a.in_ready), 32'd0);
        check("ready_after_last_b", 32'(pay_b.in_ready), 32'd0);

        stored = (n < DEP_B) ? n : DEP_B;
        pad    = (stored < PAD_WORDS) ? PAD_WORDS - stored : 0;
        k = 0;
        while (!en_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("arm_latency", 32'(k), 32'(pad + 1));
        check("en_b_with_a", 32'(en_b), 32'd1);

        if (rst_in_send) begin
            reset_n = 1'b0;
            @(negedge clk);
            check("rst_en_a", 32'(en_a), 32'd0);
            check("rst_ready_a", 32'(pay_a.in_ready), 32'd1);
            check("rst_busy_a", 32'(busy_a), 32'd0);
            check("rst_ovf_b", 32'(ovf_b), 32'd0);
            check("rst_len_a", 32'(len_a), 32'd0);
            check("rst_len_b", 32'(len_b), 32'd0);
            check("rst_rd_a", rd_data_a, 32'd0);
            reset_n    = 1'b1;
            ref_ovf[0] = 1'b0;
            ref_ovf[1] = 1'b0;
            return;
        end

        for (int i = 0; i < hold_idle; i++) begin
            @(negedge clk);
            check("en_hold", 32'(en_a), 32'd1);
        end
        if (offer) begin
            drive(1'b1, $urandom, 1'b0, 2'd0);
            check("ready_in_send", 32'(pay_a.in_ready), 32'd0);
        end
        tx_state = 4'($urandom_range(15, 1));
        @(negedge clk);
        check("en_drop_a", 32'(en_a), 32'd0);
        check("en_drop_b", 32'(en_b), 32'd0);
        check("busy_drain", 32'(busy_a), 32'd1);

        nread = ((n > PAD_WORDS) ? n : PAD_WORDS) + 1;
        if (nread > REF_N) nread = REF_N;
        for (int a = 0; a < nread; a++) issue_read(a);
        issue_read(600);
        issue_read(8191);
        rd_req = 1'b0;

        check("ready_in_drain", 32'(pay_a.in_ready), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 2'd0);
        tx_state = 4'd0;
        @(negedge clk);
        check("ready_back_a", 32'(pay_a.in_ready), 32'd1);
        check("ready_back_b", 32'(pay_b.in_ready), 32'd1);
        check("busy_back", 32'(busy_a), 32'd0);
    endtask

    // Packet monitor: one expected length/overflow pair per ipsend_en rise.
    always @(negedge clk) begin
        if (en_a && !prev_en_a) begin
            if (pkt_q_a.size() == 0) begin
                n_checks++;
                $display("FAIL pkt_a: got unexpected ipsend_en, expected none");
            end else begin
                pa = pkt_q_a.pop_front();
                check("len_a", 32'(len_a), 32'(pa.len));
                check("ovf_a", 32'(ovf_a), 32'(pa.ovf));
                check("busy_a", 32'(busy_a), 32'd1);
                $display("pkt a: Data_Length=%0d overflow=%0d", len_a, ovf_a);
            end
        end
        if (en_b && !prev_en_b) begin
            if (pkt_q_b.size() == 0) begin
                n_checks++;
                $display("FAIL pkt_b: got unexpected ipsend_en, expected none");
            end else begin
                pb = pkt_q_b.pop_front();
                check("len_b", 32'(len_b), 32'(pb.len));
                check("ovf_b", 32'(ovf_b), 32'(pb.ovf));
                $display("pkt b: Data_Length=%0d overflow=%0d", len_b, ovf_b);
            end
        end
        prev_en_a <= en_a;
        prev_en_b <= en_b;
    end

    always @(posedge clk) rd_req_d <= rd_req;

    // Read monitor: data is due one edge after the address was presented.
    always @(negedge clk) begin
        if (rd_req_d) begin
            if (rd_q_a.size() == 0 || rd_q_b.size() == 0) begin
                n_checks++;
                $display("FAIL rd_q: got read with empty queue, expected queued read");
            end else begin
                ra = rd_q_a.pop_front();
                rb = rd_q_b.pop_front();
                if (ra.chk) check($sformatf("rd_a[%0d]", ra.addr), rd_data_a, ra.exp);
                if (rb.chk) check($sformatf("rd_b[%0d]", rb.addr), rd_data_b, rb.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            ref_ovf[k] = 1'b0;
            for (int i = 0; i < REF_N; i++) begin
                ref_ok[k][i]  = 1'b0;
                ref_mem[k][i] = 32'd0;
            end
        end
        reset_n     = 1'b0;
        tx_state    = 4'd0;
        ram_rd_addr = 13'd0;
        drive(1'b0, 32'd0, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(pay_a.in_ready), 32'd1);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_en", 32'(en_a), 32'd0);
        check("reset_len", 32'(len_a), 32'd0);
        check("reset_ovf", 32'(ovf_b), 32'd0);
        check("reset_rd", rd_data_a, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        send_pkt(10, 2'd0, 0, 0, 1'b0, 1'b0);
        send_pkt(3, 2'd2, 0, 0, 1'b0, 1'b0);
        send_pkt(6, 2'd1, 3, 0, 1'b1, 1'b0);
        send_pkt(4, 2'd3, 0, 20, 1'b0, 1'b0);
        send_pkt(12, 2'd0, 1, 0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            send_pkt(int'($urandom_range(14, 1)), 2'($urandom), 2,
                     int'($urandom_range(3, 0)), 1'($urandom), 1'b0);
        end
        send_pkt(7, 2'd0, 0, 2, 1'b0, 1'b1);
        send_pkt(2, 2'd1, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        check("pkt_q_a_left", 32'(pkt_q_a.size()), 32'd0);
        check("pkt_q_b_left", 32'(pkt_q_b.size()), 32'd0);
        check("rd_q_left", 32'(rd_q_a.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
